i2c_scl_gen: RTL and testbench

Parametrised I2C SCL generator with slave clock-stretch detection, stretch timeout and bit-period strobes. It is the next-generation replacement for the fixed-divider stretch block. It sits between the I2C byte/transaction FSM, which consumes `data_clk`, `switch_range` and `bit_tick`, and the open-drain SCL pad, which is driven by `scl_oe` and sampled via `scl_in`. Divider and timeout are parameters; SCL input is synchronised internally.

---
 rtl/i2c_scl_gen_if.sv | 21 ++
 rtl/i2c_scl_gen.sv | 130 +++++++++++++
 tb/tb_i2c_scl_gen.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_scl_gen_if.sv
// Signal bundle between the I2C transaction FSM / SCL pad side and the SCL generator.
interface i2c_scl_gen_if;
  logic ena;
  logic scl_in;
  logic scl_oe;
  logic data_clk;
  logic switch_range;
  logic bit_tick;
  logic stretching;
  logic timeout;

  modport master (
    output ena, scl_in,
    input  scl_oe, data_clk, switch_range, bit_tick, stretching, timeout
  );

  modport slave (
    input  ena, scl_in,
    output scl_oe, data_clk, switch_range, bit_tick, stretching, timeout
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// Quarter-period SCL generator with slave clock-stretch hold, stretch timeout and bit strobes.
// All outputs are registered and decoded from the next-state counter.
module i2c_scl_gen #(
  parameter int DIVIDER         = 250,
  parameter int CBITS           = 10,
  parameter int STRETCH_TIMEOUT = 1023,
  parameter int TBITS           = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  i2c_scl_gen_if.slave bus
);

  localparam logic [CBITS-1:0] Q1_START  = CBITS'(DIVIDER);
  localparam logic [CBITS-1:0] Q2_START  = CBITS'(2 * DIVIDER);
  localparam logic [CBITS-1:0] Q3_START  = CBITS'(3 * DIVIDER);
  localparam logic [CBITS-1:0] CNT_LAST  = CBITS'(4 * DIVIDER - 1);
  // SCL is released at Q2_START; output flop, pad and synchroniser need 3 cycles to show it high.
  localparam logic [CBITS-1:0] CHECK_PT  = CBITS'(2 * DIVIDER + 3);
  localparam logic [TBITS-1:0] TCNT_LAST = TBITS'(STRETCH_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [TBITS-1:0] tcnt_q, tcnt_d;
  logic             timeout_q, timeout_d;
  logic             scl_oe_q, scl_oe_d;
  logic             data_clk_q, data_clk_d;
  logic             switch_range_q, switch_range_d;
  logic             bit_tick_q, bit_tick_d;

  logic scl_sync;
  logic slave_low;
  logic running_d;

  assign sync_d    = {sync_q[0], bus.scl_in};
  assign scl_sync  = sync_q[1];
  assign slave_low = (cnt_q == CHECK_PT) && !scl_sync;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tcnt_d     = '0;
    timeout_d  = timeout_q;
    bit_tick_d = 1'b0;

    if (!bus.ena) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First enabled edge presents cnt=0 on the outputs; the first wrap is a full period away.
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        ST_RUN, ST_HOLD: begin
          if (slave_low) begin
            if (tcnt_q == TCNT_LAST) begin
              timeout_d = 1'b1;
              cnt_d     = cnt_q + CBITS'(1);
              state_d   = ST_RUN;
            end else begin
              tcnt_d  = tcnt_q + TBITS'(1);
              state_d = ST_HOLD;
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            bit_tick_d = 1'b1;
            state_d    = ST_RUN;
          end else begin
            cnt_d   = cnt_q + CBITS'(1);
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign running_d = (state_d != ST_IDLE);

  always_comb begin
    scl_oe_d       = running_d && (cnt_d < Q2_START);
    data_clk_d     = running_d && (cnt_d >= Q1_START) && (cnt_d < Q3_START);
    switch_range_d = running_d && (cnt_d >= Q2_START) && (cnt_d < Q3_START);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= 2'b11;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      timeout_q      <= 1'b0;
      scl_oe_q       <= 1'b0;
      data_clk_q     <= 1'b0;
      switch_range_q <= 1'b0;
      bit_tick_q     <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tcnt_q         <= tcnt_d;
      timeout_q      <= timeout_d;
      scl_oe_q       <= scl_oe_d;
      data_clk_q     <= data_clk_d;
      switch_range_q <= switch_range_d;
      bit_tick_q     <= bit_tick_d;
    end
  end

  assign bus.scl_oe       = scl_oe_q;
  assign bus.data_clk     = data_clk_q;
  assign bus.switch_range = switch_range_q;
  assign bus.bit_tick     = bit_tick_q;
  assign bus.stretching   = (state_q == ST_HOLD);
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: three parameterisations, directed scenarios,
// then randomized stretch/enable stimulus against a quarter-arithmetic reference model.
`timescale 1ns/1ps
module tb_i2c_scl_gen;
  localparam int N        = 3;
  localparam int MAX_WAIT = 4000;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] ena_v   = '0;
  logic [N-1:0] hold    = '0;
  logic [N-1:0] pad     = '1;
  logic [N-1:0] oe_last = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2c_scl_gen_if bus_a ();
  i2c_scl_gen_if bus_b ();
  i2c_scl_gen_if bus_c ();

  i2c_scl_gen #(.DIVIDER(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  i2c_scl_gen #(.DIVIDER(4), .STRETCH_TIMEOUT(5)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  i2c_scl_gen u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  assign bus_a.ena = ena_v[0];
  assign bus_b.ena = ena_v[1];
  assign bus_c.ena = ena_v[2];
  // Wired-AND bus: master pad (1 cycle late) and a slave that may hold SCL low.
  assign bus_a.scl_in = pad[0] & ~hold[0];
  assign bus_b.scl_in = pad[1] & ~hold[1];
  assign bus_c.scl_in = pad[2] & ~hold[2];

  // Output vector bits: 5 oe, 4 data_clk, 3 switch_range, 2 bit_tick, 1 stretching, 0 timeout
  logic [5:0] got [N];
  assign got[0] = {bus_a.scl_oe, bus_a.data_clk, bus_a.switch_range, bus_a.bit_tick, bus_a.stretching, bus_a.timeout};
  assign got[1] = {bus_b.scl_oe, bus_b.data_clk, bus_b.switch_range, bus_b.bit_tick, bus_b.stretching, bus_b.timeout};
  assign got[2] = {bus_c.scl_oe, bus_c.data_clk, bus_c.switch_range, bus_c.bit_tick, bus_c.stretching, bus_c.timeout};

  function automatic int div_of(input int i);
    return (i == 2) ? 250 : 4;
  endfunction

  function automatic int to_of(input int i);
    return (i == 1) ? 5 : 1023;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position within the SCL period, quarter = pos / DIVIDER.
  int         m_pos  [N];
  int         m_held [N];
  bit         m_run  [N];
  bit         m_to   [N];
  bit         m_tick [N];
  bit         m_str  [N];
  bit         m_s1   [N];
  bit         m_s2   [N];
  logic [5:0] m_exp  [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pos[i] = 0; m_held[i] = 0; m_run[i] = 0; m_to[i] = 0;
      m_tick[i] = 0; m_str[i] = 0; m_s1[i] = 1; m_s2[i] = 1; m_exp[i] = '0;
    end
  endtask

  task automatic model_step(input int i, input bit en, input bit scl);
    int d, s, q;
    bit sync_now;
    d = div_of(i);
    s = 2 * d + 3;
    sync_now = m_s2[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = scl;
    m_tick[i] = 0;
    m_str[i] = 0;
    if (!en) begin
      m_run[i] = 0; m_pos[i] = 0; m_held[i] = 0; m_to[i] = 0;
    end else if (!m_run[i]) begin
      m_run[i] = 1; m_pos[i] = 0; m_held[i] = 0;
    end else if (m_pos[i] == s && !sync_now) begin
      if (m_held[i] == to_of(i) - 1) begin
        m_to[i] = 1; m_pos[i] = m_pos[i] + 1; m_held[i] = 0;
      end else begin
        m_held[i] = m_held[i] + 1; m_str[i] = 1;
      end
    end else begin
      m_held[i] = 0;
      if (m_pos[i] == 4 * d - 1) begin
        m_pos[i] = 0; m_tick[i] = 1;
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
    if (!m_run[i]) begin
      m_exp[i] = '0;
    end else begin
      q = m_pos[i] / d;
      m_exp[i] = {q < 2, (q == 1) || (q == 2), q == 2, m_tick[i], m_str[i], m_to[i]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < N; i++) model_step(i, ena_v[i], pad[i] & ~hold[i]);
    end
  end

  // Pad: SCL level follows the released/driven state one cycle late.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        pad[i]     = ~oe_last[i];
        oe_last[i] = got[i][5];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) check($sformatf("model_%0d", i), 32'(got[i]), 32'(m_exp[i]));
    end
  end

  task automatic wait_tick(input int i, input string tag);
    bit found;
    found = 0;
    for (int n = 0; n < MAX_WAIT && !found; n++) begin
      @(negedge clk);
      found = got[i][2];
    end
    check({tag, "_tick_seen"}, 32'(found), 32'd1);
  endtask

  // Measures one tick-to-tick period; optionally holds SCL low for 'inject' cycles from the oe fall.
  task automatic measure(input int i, input int inject, input string tag, output int len,
                         output int n_str, output int n_oe, output int n_dc, output int n_sr);
    int  inj_left;
    bit  injected, prev_oe;
    wait_tick(i, tag);
    len = 0; n_str = 0; n_oe = 0; n_dc = 0; n_sr = 0;
    inj_left = 0; injected = 0; prev_oe = got[i][5];
    do begin
      @(negedge clk);
      len++;
      if (inj_left > 0) begin
        inj_left--;
        if (inj_left == 0) hold[i] = 1'b0;
      end
      if (inject > 0 && !injected && prev_oe && !got[i][5]) begin
        hold[i] = 1'b1; inj_left = inject; injected = 1;
      end
      prev_oe = got[i][5];
      n_oe  += int'(got[i][5]);
      n_dc  += int'(got[i][4]);
      n_sr  += int'(got[i][3]);
      n_str += int'(got[i][1]);
    end while (!got[i][2] && len < MAX_WAIT);
  endtask

  initial begin
    int  len, n_str, n_oe, n_dc, n_sr, n;
    int  hl [2];
    bit  found, prev;

    repeat (3) @(negedge clk);
    check("rst_a", 32'(got[0]), 32'd0);
    check("rst_b", 32'(got[1]), 32'd0);
    check("rst_c", 32'(got[2]), 32'd0);
    rst_n = 1'b1;
    ena_v = 3'b101;

    measure(0, 0, "free", len, n_str, n_oe, n_dc, n_sr);
    check("free_period", len, 16);
    check("free_oe", n_oe, 8);
    check("free_dclk", n_dc, 8);
    check("free_sr", n_sr, 4);
    check("free_str", n_str, 0);

    measure(0, 20, "stretch", len, n_str, n_oe, n_dc, n_sr);
    check("stretch_period", len, 35);
    check("stretch_held", n_str, 19);
    check("stretch_to", 32'(got[0][0]), 32'd0);

    hold[1] = 1'b1;
    ena_v[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      measure(1, 0, "tmo", len, n_str, n_oe, n_dc, n_sr);
      check($sformatf("tmo_period_%0d", k), len, 20);
      check($sformatf("tmo_held_%0d", k), n_str, 4);
      check($sformatf("tmo_flag_%0d", k), 32'(got[1][0]), 32'd1);
    end
    ena_v[1] = 1'b0;
    @(negedge clk);
    check("tmo_cleared", 32'(got[1]), 32'd0);
    hold[1] = 1'b0;

    wait_tick(0, "dis");
    repeat (6) @(negedge clk);
    ena_v[0] = 1'b0;
    @(negedge clk);
    check("dis_idle", 32'(got[0]), 32'd0);
    ena_v[0] = 1'b1;
    @(negedge clk);
    check("reen_oe", 32'(got[0][5]), 32'd1);
    check("reen_tick", 32'(got[0][2]), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!got[0][2] && n < MAX_WAIT);
    check("reen_first_tick", n, 16);

    found = 0; prev = got[0][5];
    for (int k = 0; k < MAX_WAIT && !found; k++) begin
      @(negedge clk);
      if (prev && !got[0][5]) hold[0] = 1'b1;
      prev = got[0][5];
      found = got[0][1];
    end
    check("arst_stretch_seen", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    hold[0] = 1'b0;
    #1;
    check("arst_a", 32'(got[0]), 32'd0);
    check("arst_b", 32'(got[1]), 32'd0);
    check("arst_c", 32'(got[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(0, 0, "post_rst", len, n_str, n_oe, n_dc, n_sr);
    check("post_rst_period", len, 16);

    measure(2, 0, "dflt", len, n_str, n_oe, n_dc, n_sr);
    check("dflt_period", len, 1000);
    check("dflt_sr", n_sr, 250);
    check("dflt_oe", n_oe, 500);
    check("dflt_dclk", n_dc, 500);
    measure(2, 10, "dflt_str", len, n_str, n_oe, n_dc, n_sr);
    check("dflt_str_period", len, 1009);
    check("dflt_str_held", n_str, 9);

    hl[0] = 0; hl[1] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (hl[i] > 0) hl[i]--;
        else if ($urandom_range(0, 24) == 0) hl[i] = int'($urandom_range(1, 30));
        hold[i] = (hl[i] > 0);
        if (ena_v[i]) begin
          if ($urandom_range(0, 299) == 0) ena_v[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          ena_v[i] = 1'b1;
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
